// File: rtl/lot_gate_controller.sv
// lot_gate_controller
//   Parking-lot occupancy controller. Two photo-beams at the gate (a = outer,
//   b = inner, 1 = blocked) are synchronised and decoded by a direction FSM
//   into entry/exit events. These update a saturating car count that feeds
//   the display decoder.
// Ports
//   clk       in   system clock, all state on posedge
//   reset_n   in   asynchronous active-low reset
//   a, b      in   raw beam sensors (asynchronous)
//   count     out  occupancy 0..CAPACITY (registered)
//   full      out  count == CAPACITY (registered)
//   empty     out  count == 0 (registered)
//   enter_p   out  one-cycle pulse per accepted entry
//   exit_p    out  one-cycle pulse per accepted exit
//   reject_p  out  one-cycle pulse: entry while full or exit while empty
module lot_gate_controller #(
  parameter int unsigned CAPACITY = 16,
  parameter int unsigned CW       = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a,
  input  logic          b,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          enter_p,
  output logic          exit_p,
  output logic          reject_p
);

  localparam logic [CW-1:0] Cap = CW'(CAPACITY);
  localparam logic [CW-1:0] One = CW'(1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StEn1  = 3'd1;
  localparam logic [2:0] StEn2  = 3'd2;
  localparam logic [2:0] StEn3  = 3'd3;
  localparam logic [2:0] StEx1  = 3'd4;
  localparam logic [2:0] StEx2  = 3'd5;
  localparam logic [2:0] StEx3  = 3'd6;

  logic          a_meta_q, a_sync_q, b_meta_q, b_sync_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          enter_q, enter_d, exit_q, exit_d, reject_q, reject_d;
  logic          entry_ev, exit_ev;
  logic [1:0]    ab;

  // Two-flop synchronisers; the FSM only ever sees the synchronised pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_meta_q <= 1'b0;
      a_sync_q <= 1'b0;
      b_meta_q <= 1'b0;
      b_sync_q <= 1'b0;
    end else begin
      a_meta_q <= a;
      a_sync_q <= a_meta_q;
      b_meta_q <= b;
      b_sync_q <= b_meta_q;
    end
  end

  assign ab = {a_sync_q, b_sync_q};

  // Direction decoder: a car entering blocks a, then both, then b only, then
  // clears. Exiting is the mirror order. Unlisted codes hold the state, so
  // IDLE ignores 11 until the beams clear.
  always_comb begin
    state_d  = state_q;
    entry_ev = 1'b0;
    exit_ev  = 1'b0;
    case (state_q)
      StIdle: begin
        if (ab == 2'b10)      state_d = StEn1;
        else if (ab == 2'b01) state_d = StEx1;
      end
      StEn1: begin
        if (ab == 2'b11)      state_d = StEn2;
        else if (ab == 2'b00) state_d = StIdle;
      end
      StEn2: begin
        if (ab == 2'b01)      state_d = StEn3;
        else if (ab == 2'b10) state_d = StEn1;
      end
      StEn3: begin
        if (ab == 2'b00) begin
          state_d  = StIdle;
          entry_ev = 1'b1;
        end else if (ab == 2'b11) begin
          state_d  = StEn2;
        end
      end
      StEx1: begin
        if (ab == 2'b11)      state_d = StEx2;
        else if (ab == 2'b00) state_d = StIdle;
      end
      StEx2: begin
        if (ab == 2'b10)      state_d = StEx3;
        else if (ab == 2'b01) state_d = StEx1;
      end
      StEx3: begin
        if (ab == 2'b00) begin
          state_d = StIdle;
          exit_ev = 1'b1;
        end else if (ab == 2'b11) begin
          state_d = StEx2;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating counter; flags come from the next count so they move with it.
  always_comb begin
    count_d  = count_q;
    enter_d  = 1'b0;
    exit_d   = 1'b0;
    reject_d = 1'b0;
    if (entry_ev) begin
      if (count_q < Cap) begin
        count_d = count_q + One;
        enter_d = 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end else if (exit_ev) begin
      if (count_q != '0) begin
        count_d = count_q - One;
        exit_d  = 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end
    full_d  = (count_d == Cap);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      enter_q  <= 1'b0;
      exit_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      enter_q  <= enter_d;
      exit_q   <= exit_d;
      reject_q <= reject_d;
    end
  end

  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign enter_p  = enter_q;
  assign exit_p   = exit_q;
  assign reject_p = reject_q;

endmodule

// File: tb/tb_lot_gate_controller.sv
// Bench for lot_gate_controller: directed gate scenarios with literal
// expectations, then randomised beam traffic checked every cycle against a
// sequence-tracking reference model.
module tb_lot_gate_controller;

  localparam int Capacity = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [4:0] count;
  logic       full, empty, enter_p, exit_p, reject_p;

  int total = 0;
  int bad = 0;
  int n_en = 0;
  int n_ex = 0;
  int n_rj = 0;

  lot_gate_controller #(.CAPACITY(Capacity), .CW(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .a        (a),
    .b        (b),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .enter_p  (enter_p),
    .exit_p   (exit_p),
    .reject_p (reject_p)
  );

  always #5 clk = ~clk;

  // Reference model: a crossing is the ordered beam pattern list; track which
  // list we are walking and how far along it we are.
  typedef struct packed {
    int dir;  // 0 none, 1 entering, 2 exiting
    int pos;  // patterns matched so far, 1..3
    int cnt;
    bit en;
    bit ex;
    bit rj;
  } mstate_t;

  mstate_t    m = '0;
  logic [1:0] h1 = 2'b00;
  logic [1:0] h2 = 2'b00;

  function automatic logic [1:0] pat(int d, int p);
    logic [1:0] in_p [3];
    logic [1:0] out_p [3];
    in_p[0] = 2'b10; in_p[1] = 2'b11; in_p[2] = 2'b01;
    out_p[0] = 2'b01; out_p[1] = 2'b11; out_p[2] = 2'b10;
    return (d == 1) ? in_p[p] : out_p[p];
  endfunction

  function automatic mstate_t step(mstate_t s, logic [1:0] ab);
    mstate_t n;
    bit done;
    n = s;
    n.en = 1'b0;
    n.ex = 1'b0;
    n.rj = 1'b0;
    done = 1'b0;
    if (s.dir == 0) begin
      if (ab == pat(1, 0)) begin n.dir = 1; n.pos = 1; end
      else if (ab == pat(2, 0)) begin n.dir = 2; n.pos = 1; end
    end else if (s.pos < 3 && ab == pat(s.dir, s.pos)) begin
      n.pos = s.pos + 1;
    end else if (s.pos > 1 && ab == pat(s.dir, s.pos - 2)) begin
      n.pos = s.pos - 1;
    end else if (ab == 2'b00 && (s.pos == 1 || s.pos == 3)) begin
      done = (s.pos == 3);
      n.dir = 0;
      n.pos = 0;
    end
    if (done && s.dir == 1) begin
      if (s.cnt < Capacity) begin n.cnt = s.cnt + 1; n.en = 1'b1; end
      else n.rj = 1'b1;
    end else if (done && s.dir == 2) begin
      if (s.cnt > 0) begin n.cnt = s.cnt - 1; n.ex = 1'b1; end
      else n.rj = 1'b1;
    end
    return n;
  endfunction

  // The decoder acts on beam values captured two edges earlier.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m  <= '0;
      h1 <= 2'b00;
      h2 <= 2'b00;
    end else begin
      m  <= step(m, h2);
      h2 <= h1;
      h1 <= {a, b};
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("count", int'(count), m.cnt);
    chk("full", int'(full), int'(m.cnt == Capacity));
    chk("empty", int'(empty), int'(m.cnt == 0));
    chk("enter_p", int'(enter_p), int'(m.en));
    chk("exit_p", int'(exit_p), int'(m.ex));
    chk("reject_p", int'(reject_p), int'(m.rj));
    n_en += int'(enter_p);
    n_ex += int'(exit_p);
    n_rj += int'(reject_p);
  end

  task automatic clr();
    n_en = 0;
    n_ex = 0;
    n_rj = 0;
  endtask

  // Hold a beam pattern for n cycles; called with time at a falling edge.
  task automatic hold(input logic [1:0] v, input int n);
    {a, b} = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic play(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                      input logic [1:0] s3, input bit rnd);
    hold(s0, rnd ? int'($urandom_range(1, 5)) : 4);
    hold(s1, rnd ? int'($urandom_range(1, 5)) : 4);
    hold(s2, rnd ? int'($urandom_range(1, 5)) : 4);
    hold(s3, rnd ? int'($urandom_range(1, 5)) : 4);
  endtask

  task automatic seq_in(input bit rnd);
    play(2'b10, 2'b11, 2'b01, 2'b00, rnd);
  endtask

  task automatic seq_out(input bit rnd);
    play(2'b01, 2'b11, 2'b10, 2'b00, rnd);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    {a, b} = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clr();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Reset state and a single entry.
    chk("t1 reset count", int'(count), 0);
    chk("t1 reset empty", int'(empty), 1);
    chk("t1 reset full", int'(full), 0);
    seq_in(1'b0);
    chk("t1 count", int'(count), 1);
    chk("t1 enter pulses", n_en, 1);
    chk("t1 empty", int'(empty), 0);

    // Exit from count 3.
    seq_in(1'b0);
    seq_in(1'b0);
    clr();
    seq_out(1'b0);
    chk("t2 count", int'(count), 2);
    chk("t2 exit pulses", n_ex, 1);
    chk("t2 enter pulses", n_en, 0);

    // Backed-out entry, then a real one proves the decoder is idle again.
    clr();
    play(2'b10, 2'b11, 2'b10, 2'b00, 1'b0);
    chk("t3 count", int'(count), 2);
    chk("t3 pulses", n_en + n_ex + n_rj, 0);
    seq_in(1'b0);
    chk("t3 follow-up count", int'(count), 3);

    // Fill to capacity, then overflow.
    do_reset();
    repeat (Capacity) seq_in(1'b0);
    chk("t4 count", int'(count), 16);
    chk("t4 full", int'(full), 1);
    clr();
    seq_in(1'b0);
    chk("t4 sat count", int'(count), 16);
    chk("t4 reject pulses", n_rj, 1);
    chk("t4 enter pulses", n_en, 0);

    // Exit while empty.
    do_reset();
    seq_out(1'b0);
    chk("t5 count", int'(count), 0);
    chk("t5 reject pulses", n_rj, 1);
    chk("t5 empty", int'(empty), 1);

    // Asynchronous reset mid-entry, released with both beams blocked.
    do_reset();
    repeat (5) seq_in(1'b0);
    chk("t6 pre count", int'(count), 5);
    clr();
    hold(2'b10, 4);
    hold(2'b11, 4);
    hold(2'b01, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("t6 async count", int'(count), 0);
    chk("t6 async empty", int'(empty), 1);
    {a, b} = 2'b11;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6 held count", int'(count), 0);
    chk("t6 held pulses", n_en + n_ex + n_rj, 0);
    hold(2'b00, 4);
    seq_in(1'b0);
    chk("t6 fresh count", int'(count), 1);
    chk("t6 fresh enter", n_en, 1);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) do_reset();
      else if (r < 45) seq_in(1'b1);
      else if (r < 70) seq_out(1'b1);
      else if (r < 82) play(2'b10, 2'b11, 2'b10, 2'b00, 1'b1);
      else hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end
    hold(2'b00, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
